// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 raster constants and the line/frame total helper
// for the VGA timing generator.
package vga_pkg;

    localparam int unsigned VGA_H_DISP  = 640;
    localparam int unsigned VGA_H_FRONT = 16;
    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_H_BACK  = 48;
    localparam int unsigned VGA_V_DISP  = 480;
    localparam int unsigned VGA_V_FRONT = 10;
    localparam int unsigned VGA_V_SYNC  = 2;
    localparam int unsigned VGA_V_BACK  = 33;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
    } spr_pos_t;

    typedef struct packed {
        logic [15:0] y;
        logic [15:0] x;
        logic [15:0] h;
        logic [15:0] w;
    } spr_cfg_t;

    function automatic int unsigned vga_total(input int unsigned disp, input int unsigned front,
                                              input int unsigned sync, input int unsigned back);
        return disp + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_spr_hit.sv
// Combinational window test for one sprite: hit flag plus offsets of the pixel
// inside the window. Bounds are compared in 17 bits so X+W never wraps.
module vga_spr_hit
    import vga_pkg::*;
#(
    parameter int unsigned CW = 12
) (
    input  logic          vid_i,
    input  logic [CW-1:0] x_i,
    input  logic [CW-1:0] y_i,
    input  spr_cfg_t      cfg_i,
    output logic          hit_o,
    output logic [15:0]   xoff_o,
    output logic [15:0]   yoff_o
);

    logic [16:0] x17, y17, x_lo, x_hi, y_lo, y_hi;

    always_comb begin
        x17    = 17'(x_i);
        y17    = 17'(y_i);
        x_lo   = {1'b0, cfg_i.x};
        y_lo   = {1'b0, cfg_i.y};
        x_hi   = x_lo + {1'b0, cfg_i.w};
        y_hi   = y_lo + {1'b0, cfg_i.h};
        hit_o  = vid_i && (x17 >= x_lo) && (x17 < x_hi) && (y17 >= y_lo) && (y17 < y_hi);
        xoff_o = x17[15:0] - cfg_i.x;
        yoff_o = y17[15:0] - cfg_i.y;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator with NUM_SPR shadowed sprite windows.
// Optional line interrupt (irq_line/line_irq) when VGA_TIMING_LINE_IRQ_EN is defined.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_DISP  = VGA_H_DISP,
    parameter int unsigned H_FRONT = VGA_H_FRONT,
    parameter int unsigned H_SYNC  = VGA_H_SYNC,
    parameter int unsigned H_BACK  = VGA_H_BACK,
    parameter int unsigned V_DISP  = VGA_V_DISP,
    parameter int unsigned V_FRONT = VGA_V_FRONT,
    parameter int unsigned V_SYNC  = VGA_V_SYNC,
    parameter int unsigned V_BACK  = VGA_V_BACK,
    parameter int unsigned CW      = 12,
    parameter int unsigned NUM_SPR = 4,
    parameter bit          HS_POL  = 1'b0,
    parameter bit          VS_POL  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [32*NUM_SPR-1:0]     spr_pos,
    input  logic [32*NUM_SPR-1:0]     spr_size,
    output logic                      hs,
    output logic                      vs,
    output logic                      vidon,
    output logic [CW-1:0]             lcd_xpos,
    output logic [CW-1:0]             lcd_ypos,
    output logic [NUM_SPR-1:0]        spr_on,
    output logic                      spr_hit,
    output logic [$clog2(NUM_SPR):0]  spr_id,
    output logic [15:0]               spr_xoff,
    output logic [15:0]               spr_yoff,
    output logic                      frame_start,
    output logic                      line_start
`ifdef VGA_TIMING_LINE_IRQ_EN
    ,
    input  logic [CW-1:0]             irq_line,
    output logic                      line_irq
`endif
);

    localparam int unsigned H_TOTAL = vga_total(H_DISP, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = vga_total(V_DISP, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned IDW     = $clog2(NUM_SPR) + 1;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_SYN  = CW'(H_SYNC);
    localparam logic [CW-1:0] V_SYN  = CW'(V_SYNC);
    localparam logic [CW-1:0] H_BEG  = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] V_BEG  = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] H_END  = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] V_END  = CW'(V_SYNC + V_BACK + V_DISP);

    logic          run_q;
    logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
    logic          at_last, cfg_load;

    spr_cfg_t cfg_q  [NUM_SPR];
    spr_cfg_t cfg_in [NUM_SPR];

    logic               vid_c;
    logic [CW-1:0]      x_c, y_c;
    logic [NUM_SPR-1:0] hit_c;
    logic [15:0]        xoff_c [NUM_SPR];
    logic [15:0]        yoff_c [NUM_SPR];
    logic               found_c;
    logic [IDW-1:0]     id_c;
    logic [15:0]        wxoff_c, wyoff_c;

    logic               hs_q, vs_q, vidon_q, fs_q, ls_q, spr_hit_q;
    logic [CW-1:0]      xpos_q, ypos_q;
    logic [NUM_SPR-1:0] spr_on_q;
    logic [IDW-1:0]     spr_id_q;
    logic [15:0]        xoff_q, yoff_q;

    always_comb begin
        hc_d    = '0;
        vc_d    = '0;
        at_last = (hc_q == H_LAST) && (vc_q == V_LAST);
        if (run_q) begin
            if (hc_q == H_LAST) begin
                vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
            end else begin
                hc_d = hc_q + 1'b1;
                vc_d = vc_q;
            end
        end
    end

    // Shadow copy points: reset, the cycle run rises, and the last pixel of a frame.
    assign cfg_load = rst || (en && !run_q) || (run_q && at_last);

    always_comb begin
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            cfg_in[i].x = spr_pos[32*i +: 16];
            cfg_in[i].y = spr_pos[32*i+16 +: 16];
            cfg_in[i].w = spr_size[32*i +: 16];
            cfg_in[i].h = spr_size[32*i+16 +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q <= 1'b0;
            hc_q  <= '0;
            vc_q  <= '0;
        end else begin
            run_q <= en;
            hc_q  <= hc_d;
            vc_q  <= vc_d;
        end
        if (cfg_load) begin
            cfg_q <= cfg_in;
        end
    end

    always_comb begin
        vid_c = run_q && (hc_q >= H_BEG) && (hc_q < H_END) && (vc_q >= V_BEG) && (vc_q < V_END);
        x_c   = vid_c ? hc_q - H_BEG : '0;
        y_c   = vid_c ? vc_q - V_BEG : '0;
    end

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
        vga_spr_hit #(.CW(CW)) u_hit (
            .vid_i  (vid_c),
            .x_i    (x_c),
            .y_i    (y_c),
            .cfg_i  (cfg_q[g]),
            .hit_o  (hit_c[g]),
            .xoff_o (xoff_c[g]),
            .yoff_o (yoff_c[g])
        );
    end

    always_comb begin
        found_c = 1'b0;
        id_c    = '0;
        wxoff_c = '0;
        wyoff_c = '0;
        for (int unsigned i = 0; i < NUM_SPR; i++) begin
            if (hit_c[i] && !found_c) begin
                found_c = 1'b1;
                id_c    = IDW'(i);
                wxoff_c = xoff_c[i];
                wyoff_c = yoff_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !run_q) begin
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            vidon_q   <= 1'b0;
            xpos_q    <= '0;
            ypos_q    <= '0;
            spr_on_q  <= '0;
            spr_hit_q <= 1'b0;
            spr_id_q  <= '0;
            xoff_q    <= '0;
            yoff_q    <= '0;
            fs_q      <= 1'b0;
            ls_q      <= 1'b0;
        end else begin
            hs_q      <= (hc_q < H_SYN) ? HS_POL : ~HS_POL;
            vs_q      <= (vc_q < V_SYN) ? VS_POL : ~VS_POL;
            vidon_q   <= vid_c;
            xpos_q    <= x_c;
            ypos_q    <= y_c;
            spr_on_q  <= hit_c;
            spr_hit_q <= found_c;
            spr_id_q  <= id_c;
            xoff_q    <= wxoff_c;
            yoff_q    <= wyoff_c;
            fs_q      <= (hc_q == '0) && (vc_q == '0);
            ls_q      <= (hc_q == '0);
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign vidon       = vidon_q;
    assign lcd_xpos    = xpos_q;
    assign lcd_ypos    = ypos_q;
    assign spr_on      = spr_on_q;
    assign spr_hit     = spr_hit_q;
    assign spr_id      = spr_id_q;
    assign spr_xoff    = xoff_q;
    assign spr_yoff    = yoff_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

`ifdef VGA_TIMING_LINE_IRQ_EN
    logic [CW-1:0] irq_q;
    logic          irq_hit_c, line_irq_q;

    // Widened by one bit so V_BEG + irq_line cannot alias back onto a display line.
    always_comb begin
        irq_hit_c = run_q && (hc_q == H_BEG)
                 && ({1'b0, irq_q} < (CW+1)'(V_DISP))
                 && ({1'b0, vc_q} == ({1'b0, V_BEG} + {1'b0, irq_q}));
    end

    always_ff @(posedge clk) begin
        if (cfg_load) begin
            irq_q <= irq_line;
        end
        if (rst || !run_q) begin
            line_irq_q <= 1'b0;
        end else begin
            line_irq_q <= irq_hit_c;
        end
    end

    assign line_irq = line_irq_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a small-raster instance checked cycle-by-cycle against a
// scoreboard model, plus a default 640x480 instance checked with directed counts.
module tb_vga_timing_gen;

    localparam int HD = 16, HF = 2, HSY = 3, HB = 4, HT = HD + HF + HSY + HB;
    localparam int VD = 12, VF = 2, VSY = 2, VB = 3, VT = VD + VF + VSY + VB;
    localparam int FR = HT * VT;
    localparam int NS = 4;
`ifdef VGA_TIMING_LINE_IRQ_EN
    localparam int IRQ_ON = 1;
`else
    localparam int IRQ_ON = 0;
`endif

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        vid;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  on;
        logic        hit;
        logic [2:0]  id;
        logic [15:0] xo;
        logic [15:0] yo;
        logic        fs;
        logic        ls;
        logic        irq;
    } out_t;

    logic clk, rst, en, en_def;
    logic [32*NS-1:0] spr_pos, spr_size;
    logic [7:0] irq_line;
    logic hs, vs, vidon, spr_hit, frame_start, line_start, line_irq;
    logic [7:0] lcd_xpos, lcd_ypos;
    logic [3:0] spr_on;
    logic [2:0] spr_id;
    logic [15:0] spr_xoff, spr_yoff;

    logic d_hs, d_vs, d_vidon, d_hit, d_fs, d_ls;
    logic [11:0] d_x, d_y;
    logic [3:0] d_on;
    logic [2:0] d_id;
    logic [15:0] d_xo, d_yo;
    logic [31:0] d_zero;
`ifdef VGA_TIMING_LINE_IRQ_EN
    logic [11:0] d_irq_line;
    logic d_irq;
    assign d_irq_line = '1;
`endif

    int pass_cnt = 0, total_cnt = 0;

    assign d_zero = '0;

    vga_timing_gen #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HSY), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VSY), .V_BACK(VB),
        .CW(8), .NUM_SPR(NS), .HS_POL(1'b1), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .spr_pos(spr_pos), .spr_size(spr_size),
        .hs(hs), .vs(vs), .vidon(vidon), .lcd_xpos(lcd_xpos), .lcd_ypos(lcd_ypos),
        .spr_on(spr_on), .spr_hit(spr_hit), .spr_id(spr_id),
        .spr_xoff(spr_xoff), .spr_yoff(spr_yoff),
        .frame_start(frame_start), .line_start(line_start)
`ifdef VGA_TIMING_LINE_IRQ_EN
        , .irq_line(irq_line), .line_irq(line_irq)
`endif
    );
`ifndef VGA_TIMING_LINE_IRQ_EN
    assign line_irq = 1'b0;
`endif

    vga_timing_gen #(.NUM_SPR(1)) u_def (
        .clk(clk), .rst(rst), .en(en_def), .spr_pos(d_zero), .spr_size(d_zero),
        .hs(d_hs), .vs(d_vs), .vidon(d_vidon), .lcd_xpos(d_x), .lcd_ypos(d_y),
        .spr_on(d_on[0]), .spr_hit(d_hit), .spr_id(d_id[1:0]),
        .spr_xoff(d_xo), .spr_yoff(d_yo),
        .frame_start(d_fs), .line_start(d_ls)
`ifdef VGA_TIMING_LINE_IRQ_EN
        , .irq_line(d_irq_line), .line_irq(d_irq)
`endif
    );
    assign d_on[3:1] = '0;
    assign d_id[2]   = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard model: at each edge, the output due after this edge is pushed.
    out_t exp_q[$];
    int   m_hc = 0, m_vc = 0, m_irq = 0;
    bit   m_run = 0, m_load;
    int   sx[NS], sy[NS], sw[NS], sh[NS];

    function automatic out_t idle_out();
        out_t e;
        e    = '0;
        e.vs = 1'b1;
        return e;
    endfunction

    function automatic out_t model_out();
        out_t e;
        int x, y;
        bit vid;
        e   = idle_out();
        x   = m_hc - (HSY + HB);
        y   = m_vc - (VSY + VB);
        vid = (x >= 0) && (x < HD) && (y >= 0) && (y < VD);
        e.hs  = (m_hc < HSY);
        e.vs  = !(m_vc < VSY);
        e.vid = vid;
        if (vid) begin
            e.x = 8'(x);
            e.y = 8'(y);
        end
        for (int i = NS - 1; i >= 0; i--) begin
            if (vid && x >= sx[i] && x < sx[i] + sw[i] && y >= sy[i] && y < sy[i] + sh[i]) begin
                e.on[i] = 1'b1;
                e.id    = 3'(i);
                e.xo    = 16'(x - sx[i]);
                e.yo    = 16'(y - sy[i]);
            end
        end
        e.hit = |e.on;
        e.fs  = (m_hc == 0) && (m_vc == 0);
        e.ls  = (m_hc == 0);
        if (IRQ_ON == 1)
            e.irq = (m_irq < VD) && (m_hc == HSY + HB) && (m_vc == VSY + VB + m_irq);
        return e;
    endfunction

    always @(posedge clk) begin
        exp_q.push_back((!rst && m_run) ? model_out() : idle_out());
        m_load = rst || (en && !m_run) || (m_run && m_hc == HT - 1 && m_vc == VT - 1);
        if (m_load) begin
            for (int i = 0; i < NS; i++) begin
                sx[i] = int'(spr_pos[32*i +: 16]);
                sy[i] = int'(spr_pos[32*i+16 +: 16]);
                sw[i] = int'(spr_size[32*i +: 16]);
                sh[i] = int'(spr_size[32*i+16 +: 16]);
            end
            m_irq = int'(irq_line);
        end
        if (rst || !m_run) begin
            m_hc = 0;
            m_vc = 0;
        end else begin
            m_hc++;
            if (m_hc == HT) begin
                m_hc = 0;
                m_vc++;
                if (m_vc == VT) m_vc = 0;
            end
        end
        m_run = !rst && en;
    end

    always @(negedge clk) begin
        out_t e, got;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = {hs, vs, vidon, lcd_xpos, lcd_ypos, spr_on, spr_hit, spr_id,
                   spr_xoff, spr_yoff, frame_start, line_start, line_irq};
            total_cnt++;
            assert (got === e) pass_cnt++;
            else $error("FAIL sb_out t=%0t observed=%h expected=%h", $time, got, e);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_spr(input int i, input int x, input int y, input int w, input int h);
        spr_pos[32*i +: 32]  = {16'(y), 16'(x)};
        spr_size[32*i +: 32] = {16'(h), 16'(w)};
    endtask

    task automatic seek(input int x, input int y, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FR && !ok; i++) begin
            tick();
            if (vidon && lcd_xpos == 8'(x) && lcd_ypos == 8'(y)) ok = 1'b1;
        end
    endtask

    task automatic seek_on0(output bit ok, output int x, output int y);
        ok = 1'b0; x = -1; y = -1;
        for (int i = 0; i < 2 * FR && !ok; i++) begin
            tick();
            if (spr_on[0]) begin
                ok = 1'b1; x = int'(lcd_xpos); y = int'(lcd_ypos);
            end
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2 * FR && !ok; i++) begin
            tick();
            if (frame_start) ok = 1'b1;
        end
    endtask

    // Samples one whole frame starting at the current (frame_start) cycle.
    task automatic count_frame(output int c0, output int c1, output int c2, output int c3,
                               output int chit, output int cirq, output int ix, output int iy);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0; chit = 0; cirq = 0; ix = -1; iy = -1;
        for (int i = 0; i < FR; i++) begin
            c0 += int'(spr_on[0]); c1 += int'(spr_on[1]);
            c2 += int'(spr_on[2]); c3 += int'(spr_on[3]);
            chit += int'(spr_hit);
            if (line_irq) begin
                cirq++; ix = int'(lcd_xpos); iy = int'(lcd_ypos);
            end
            tick();
        end
    endtask

    initial begin
        bit ok;
        int c0, c1, c2, c3, chit, cirq, ix, iy;
        int n_hs, n_vs, n_vid, first, fx, fy, lx, ly;

        rst = 1'b1; en = 1'b0; en_def = 1'b0; irq_line = 8'd5;
        spr_pos = '0; spr_size = '0;
        set_spr(0, 3, 4, 4, 2);
        set_spr(1, 0, 0, 0, 5);
        set_spr(2, 5, 4, 3, 3);
        set_spr(3, 14, 10, 100, 100);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // Default 640x480 instance: reset state, start latency, sync/active widths.
        tick();
        check("def_rst_hs", d_hs, 1);
        check("def_rst_vs", d_vs, 1);
        check("def_rst_vidon", d_vidon, 0);
        check("def_rst_fs", d_fs, 0);
        @(negedge clk) en_def = 1'b1;
        tick();
        check("def_fs_early", d_fs, 0);
        tick();
        check("def_fs_lat2", d_fs, 1);
        check("def_ls_with_fs", d_ls, 1);
        n_hs = 0; n_vs = 0; n_vid = 0;
        for (int i = 0; i < 3 * 800; i++) begin
            n_hs += int'(!d_hs); n_vs += int'(!d_vs); n_vid += int'(d_vidon);
            tick();
        end
        check("def_hs_low_3lines", n_hs, 3 * 96);
        check("def_vs_low_3lines", n_vs, 2 * 800);
        check("def_vidon_vsync", n_vid, 0);
        repeat (32 * 800) tick();
        n_vid = 0; first = -1; fx = -1; fy = -1; lx = -1; ly = -1;
        for (int i = 0; i < 800; i++) begin
            if (d_vidon) begin
                n_vid++;
                if (first < 0) begin
                    first = i; fx = int'(d_x); fy = int'(d_y);
                end
            end
            if (i == 783) begin
                lx = int'(d_x); ly = int'(d_y);
            end
            tick();
        end
        check("def_vidon_line35", n_vid, 640);
        check("def_first_px_hc", first, 144);
        check("def_first_px_x", fx, 0);
        check("def_first_px_y", fy, 0);
        check("def_hc783_x", lx, 639);
        check("def_hc783_y", ly, 0);
        @(negedge clk) en_def = 1'b0;

        // Small raster instance.
        @(negedge clk) en = 1'b1;
        tick();
        check("fs_early", frame_start, 0);
        tick();
        check("fs_lat2", frame_start, 1);
        check("hs_active_high", hs, 1);
        count_frame(c0, c1, c2, c3, chit, cirq, ix, iy);
        check("spr0_pixels", c0, 8);
        check("spr1_w0_never", c1, 0);
        check("spr2_pixels", c2, 9);
        check("spr3_clipped", c3, 4);
        check("hit_union", chit, 17);
        check("irq_per_frame", cirq, IRQ_ON);
        if (IRQ_ON == 1) begin
            check("irq_x", ix, 0);
            check("irq_y", iy, 5);
        end

        seek(5, 4, ok);
        check("seek_overlap", ok, 1);
        check("overlap_on", spr_on, 4'b0101);
        check("overlap_id", spr_id, 0);
        check("overlap_xoff", spr_xoff, 2);
        check("overlap_yoff", spr_yoff, 0);
        seek(15, 10, ok);
        check("seek_clip", ok, 1);
        check("clip_on", spr_on, 4'b1000);
        check("clip_id", spr_id, 3);
        check("clip_xoff", spr_xoff, 1);
        seek(15, 11, ok);
        check("seek_last_px", ok, 1);
        tick();
        check("after_last_px_vidon", vidon, 0);

        // Mid-frame config change must only take effect from the next frame.
        wait_fs(ok);
        check("wait_fs_a", ok, 1);
        @(negedge clk) set_spr(0, 0, 0, 4, 2);
        seek_on0(ok, fx, fy);
        check("old_cfg_seen", ok, 1);
        check("old_cfg_x", fx, 3);
        check("old_cfg_y", fy, 4);
        wait_fs(ok);
        check("wait_fs_b", ok, 1);
        seek_on0(ok, fx, fy);
        check("new_cfg_x", fx, 0);
        check("new_cfg_y", fy, 0);

        // irq_line change is shadowed too: one more firing frame, then silence.
        wait_fs(ok);
        check("wait_fs_c", ok, 1);
        @(negedge clk) irq_line = 8'd20;
        count_frame(c0, c1, c2, c3, chit, cirq, ix, iy);
        check("irq_shadowed", cirq, IRQ_ON);
        count_frame(c0, c1, c2, c3, chit, cirq, ix, iy);
        check("irq_out_of_range", cirq, 0);

        // Drop enable mid-line.
        seek(8, 3, ok);
        check("seek_midline", ok, 1);
        @(negedge clk) en = 1'b0;
        tick();
        tick();
        check("stop_hs", hs, 0);
        check("stop_vs", vs, 1);
        check("stop_vidon", vidon, 0);
        check("stop_x", lcd_xpos, 0);
        n_hs = 0;
        for (int i = 0; i < 50; i++) begin
            n_hs += int'(line_start) + int'(frame_start);
            tick();
        end
        check("stop_no_pulses", n_hs, 0);

        @(negedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
